// File: rtl/apb4_regbank_pkg.sv
// apb4_regbank_pkg: word indices, register kinds, access FSM states and strobe helper for the APB4 register bank
package apb4_regbank_pkg;
  localparam int IDX_CTRL = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_IRQ_STAT = 2;
  localparam int IDX_IRQ_EN = 3;
  localparam int IDX_SCRATCH0 = 4;
  localparam int MAX_DATA_W = 128;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;
  typedef enum logic [1:0] {RK_RW, RK_RO, RK_W1C} reg_kind_e;
  typedef enum logic {ST_IDLE, ST_ACCESS} acc_state_e;
  function automatic reg_kind_e reg_kind(input int idx);
    return (idx >= IDX_SCRATCH0 || idx == IDX_CTRL || idx == IDX_IRQ_EN) ? RK_RW :
           idx == IDX_STATUS ? RK_RO : RK_W1C;
  endfunction
  function automatic logic [MAX_DATA_W-1:0] strb_mask(input logic [MAX_STRB_W-1:0] strb);
    logic [MAX_DATA_W-1:0] m;
    for (int b = 0; b < MAX_STRB_W; b++) m[8*b+:8] = {8{strb[b]}};
    return m;
  endfunction
endpackage

// File: rtl/apb4_regbank_access_fsm.sv
// apb_access_fsm: APB setup/access sequencing with a programmable wait-state counter
module apb_access_fsm
  import apb4_regbank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic commit,
  output logic abort
);
  acc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic setup, access;
  assign setup = psel & ~penable;
  assign access = psel & penable;
  assign commit = access & (state_q == ST_ACCESS) & (cnt_q == 4'd0);
  // an access phase with no preceding setup is answered at once with an error
  assign abort = access & (state_q == ST_IDLE);
  assign pready = commit | abort;
  always_comb begin
    state_d = (setup || (state_q == ST_ACCESS && access && cnt_q != 4'd0)) ? ST_ACCESS : ST_IDLE;
    cnt_d = setup ? 4'(WAIT_STATES) :
            (state_q == ST_ACCESS && access && cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/apb4_regbank.sv
// apb4_regbank: APB4 control/status register bank with byte strobes, wait states, error response and W1C irq block
module apb4_regbank
  import apb4_regbank_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  input  logic [DATA_W-1:0]   status_i,
  input  logic [DATA_W-1:0]   irq_set_i,
  output logic [DATA_W-1:0]   ctrl_o,
  output logic                irq_o
);
  logic [ADDR_W-3:0] idx;
  int idx_i;
  logic pready_w, commit, abort, err, wr, irq_q, irq_d, unused_mask;
  logic [MAX_DATA_W-1:0] mask_full;
  logic [DATA_W-1:0] mask, w1c, rdata;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  apb_access_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .pclk(pclk),
    .preset(preset),
    .psel(psel),
    .penable(penable),
    .pready(pready_w),
    .commit(commit),
    .abort(abort)
  );
  assign idx = paddr[ADDR_W-1:2];
  assign idx_i = int'(idx);
  assign err = (paddr[1:0] != 2'b00) | (idx_i >= NUM_REGS) | (pwrite & (idx_i == IDX_STATUS));
  assign wr = commit & pwrite & ~err;
  assign mask_full = strb_mask((MAX_STRB_W)'(pstrb));
  assign mask = mask_full[DATA_W-1:0];
  assign unused_mask = ^mask_full;
  assign w1c = (wr && idx_i == IDX_IRQ_STAT) ? (pwdata & mask) : '0;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = (wr && idx_i == i && reg_kind(i) == RK_RW) ? ((regs_q[i] & ~mask) | (pwdata & mask)) : regs_q[i];
    // new set pulses are OR-ed in after the clear so a same-cycle set survives
    regs_d[IDX_IRQ_STAT] = (regs_q[IDX_IRQ_STAT] & ~w1c) | irq_set_i;
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) if (idx_i == i) rdata = (i == IDX_STATUS) ? status_i : regs_q[i];
  end
  assign irq_d = |(regs_q[IDX_IRQ_STAT] & regs_q[IDX_IRQ_EN]);
  assign pready = pready_w;
  assign pslverr = pready_w & (abort | err);
  assign prdata = (pready_w && !pslverr && !pwrite) ? rdata : '0;
  assign ctrl_o = regs_q[IDX_CTRL];
  assign irq_o = irq_q;
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == IDX_CTRL) ? CTRL_RST : '0;
      irq_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      irq_q <= irq_d;
    end
endmodule

// File: tb/tb_apb4_regbank.sv
// tb_apb4_regbank: scoreboard bench driving three banks (0, 2 and 3 wait states) over a shared APB bus
module tb_apb4_regbank;
  localparam logic [31:0] RST1 = 32'hC0DE_0001;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [7:0] paddr = '0;
  logic [2:0] psel = '0;
  logic penable = 1'b0;
  logic pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [31:0] status_i = '0;
  logic [31:0] irq_set_i = '0;
  logic [31:0] prdata [3];
  logic [31:0] ctrl_o [3];
  logic pready [3];
  logic pslverr [3];
  logic irq_o [3];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0;
  typedef struct {string tag; logic [31:0] rd; logic err; int waits;} exp_t;
  exp_t sb[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb4_regbank #(
      .WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 3),
      .CTRL_RST(g == 0 ? 32'h0 : RST1)
    ) u_dut (
      .pclk(pclk),
      .preset(preset),
      .paddr(paddr),
      .psel(psel[g]),
      .penable(penable),
      .pwrite(pwrite),
      .pwdata(pwdata),
      .pstrb(pstrb),
      .prdata(prdata[g]),
      .pready(pready[g]),
      .pslverr(pslverr[g]),
      .status_i(status_i),
      .irq_set_i(irq_set_i),
      .ctrl_o(ctrl_o[g]),
      .irq_o(irq_o[g])
    );
  end

  function automatic int ws(input int d);
    return d == 0 ? 0 : d == 1 ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 of the completion edge so transfers can chain
  task automatic xfer(input int d, input string tag, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rd, input logic err);
    exp_t e;
    int n;
    n = 0;
    sb.push_back('{tag, rd, err, ws(d)});
    psel = 3'b001 << d;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    pstrb = st;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(negedge pclk);
    while (!pready[d] && n < 40) begin
      chk({tag, "_wait_rd"}, prdata[d], 32'h0);
      n++;
      @(negedge pclk);
    end
    e = sb.pop_front();
    chk({e.tag, "_rd"}, prdata[d], e.rd);
    chk({e.tag, "_err"}, 32'(pslverr[d]), 32'(e.err));
    chk({e.tag, "_waits"}, n, e.waits);
    @(posedge pclk);
    #1 psel = '0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", 32'(pready[d]), 32'h0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'h0);
      chk("rst_prdata", prdata[d], 32'h0);
      chk("rst_irq", 32'(irq_o[d]), 32'h0);
      chk("rst_ctrl", ctrl_o[d], d == 0 ? 32'h0 : RST1);
    end
    preset = 1'b0;
    @(posedge pclk);
    #1;
    // reset asserted in the middle of a waited write to CTRL
    psel = 3'b010;
    pwrite = 1'b1;
    paddr = 8'h00;
    pwdata = 32'hFFFF_FFFF;
    pstrb = 4'hF;
    penable = 1'b0;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #2 preset = 1'b1;
    psel = '0;
    penable = 1'b0;
    #1;
    chk("t1_pready", 32'(pready[1]), 32'h0);
    chk("t1_ctrl", ctrl_o[1], RST1);
    chk("t1_irq", 32'(irq_o[1]), 32'h0);
    chk("t1_prdata", prdata[1], 32'h0);
    @(posedge pclk);
    #1 preset = 1'b0;
    xfer(1, "t1_read", 1'b0, 8'h00, 32'h0, 4'h0, RST1, 1'b0);
    // byte-strobed CTRL write
    xfer(0, "t2_wr", 1'b1, 8'h00, 32'hA5A5_5A5A, 4'b0101, 32'h0, 1'b0);
    xfer(0, "t2_rd", 1'b0, 8'h00, 32'h0, 4'h0, 32'h00A5_005A, 1'b0);
    chk("t2_ctrl_o", ctrl_o[0], 32'h00A5_005A);
    // three wait states on the scratch register
    xfer(2, "t3_wr", 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer(2, "t3_rd", 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    // error responses leave state untouched
    status_i = 32'h5A5A_1234;
    xfer(0, "t4_unaligned_rd", 1'b0, 8'h42, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, "t4_status_wr", 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer(0, "t4_range_rd", 1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, "t4_unaligned_wr", 1'b1, 8'h01, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer(0, "t4_status_rd", 1'b0, 8'h04, 32'h0, 4'h0, 32'h5A5A_1234, 1'b0);
    psel = 3'b001;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 8'h00;
    pwdata = 32'hFFFF_FFFF;
    pstrb = 4'hF;
    @(negedge pclk);
    chk("t4_nosetup_rdy", 32'(pready[0]), 32'h1);
    chk("t4_nosetup_err", 32'(pslverr[0]), 32'h1);
    @(posedge pclk);
    #1 psel = '0;
    penable = 1'b0;
    xfer(0, "t4_ctrl_kept", 1'b0, 8'h00, 32'h0, 4'h0, 32'h00A5_005A, 1'b0);
    // interrupt set, W1C race and clear
    xfer(0, "t5_en", 1'b1, 8'h0C, 32'h8, 4'hF, 32'h0, 1'b0);
    irq_set_i = 32'h8;
    @(posedge pclk);
    #1 irq_set_i = '0;
    @(negedge pclk);
    chk("t5_irq_lag", 32'(irq_o[0]), 32'h0);
    @(posedge pclk);
    #1 chk("t5_irq_set", 32'(irq_o[0]), 32'h1);
    irq_set_i = 32'h8;
    xfer(0, "t5_w1c_race", 1'b1, 8'h08, 32'h8, 4'hF, 32'h0, 1'b0);
    irq_set_i = '0;
    xfer(0, "t5_stat_kept", 1'b0, 8'h08, 32'h0, 4'h0, 32'h8, 1'b0);
    xfer(0, "t5_w1c", 1'b1, 8'h08, 32'h8, 4'hF, 32'h0, 1'b0);
    chk("t5_irq_hold", 32'(irq_o[0]), 32'h1);
    @(posedge pclk);
    #1 chk("t5_irq_clr", 32'(irq_o[0]), 32'h0);
    xfer(0, "t5_stat_clr", 1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0);
    // back-to-back transfers with no idle cycle
    c0 = cyc;
    xfer(0, "t6_wr1", 1'b1, 8'h14, 32'h1111_2222, 4'hF, 32'h0, 1'b0);
    xfer(0, "t6_rd", 1'b0, 8'h14, 32'h0, 4'h0, 32'h1111_2222, 1'b0);
    xfer(0, "t6_wr2", 1'b1, 8'h18, 32'h3333_4444, 4'hF, 32'h0, 1'b0);
    chk("t6_cycles", cyc - c0, 32'd6);
    xfer(0, "t6_rd2", 1'b0, 8'h18, 32'h0, 4'h0, 32'h3333_4444, 1'b0);
    xfer(0, "t6_nostrb_wr", 1'b1, 8'h14, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    xfer(0, "t6_nostrb_rd", 1'b0, 8'h14, 32'h0, 4'h0, 32'h1111_2222, 1'b0);
    chk("sb_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
